fifo_push_arbiter: RTL and testbench

FIFO_PUSH_ARBITER -- requirements
Module: fifo_push_arbiter

---
 rtl/fifo_push_arbiter.sv | 112 +++++++++++
 tb/tb_fifo_push_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_push_arbiter.sv
// Two-producer arbiter that owns a shared FIFO write port in bursts.
// It grants round-robin on contention and respects FIFO backpressure.
module fifo_push_arbiter #(
  parameter int FIFO_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  input  logic [FIFO_WIDTH-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [FIFO_WIDTH-1:0] req1_data,
  output logic                  req1_ready,
  input  logic                  fifo_full,
  output logic                  fifo_push,
  output logic [FIFO_WIDTH-1:0] fifo_data_in,
  output logic                  grant_active,
  output logic                  grant_id,
  output logic [1:0]            dbg_state_o,
  output logic [3:0]            dbg_burst_cnt_o
);

  // Handshake: a word moves when reqx_valid && reqx_ready at a rising edge;
  // ready is only ever raised for the owner, and only when the FIFO is not full.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

  state_t     state_q, state_d;
  logic [3:0] burst_cnt_q, burst_cnt_d;
  logic       grant_id_q, grant_id_d;

  logic own_valid;
  logic other_valid;
  logic limit_hit;
  logic pick1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      burst_cnt_q <= 4'd0;
      grant_id_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      grant_id_q  <= grant_id_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    burst_cnt_d  = burst_cnt_q;
    grant_id_d   = grant_id_q;
    fifo_push    = 1'b0;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    fifo_data_in = '0;
    grant_active = 1'b0;
    own_valid    = 1'b0;
    other_valid  = 1'b0;
    limit_hit    = 1'b0;
    pick1        = 1'b0;

    case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          // On contention, the producer that did not own the port last wins.
          pick1       = (req0_valid && req1_valid) ? ~grant_id_q : req1_valid;
          state_d     = pick1 ? OWN1 : OWN0;
          grant_id_d  = pick1;
          burst_cnt_d = 4'd0;
        end
      end
      OWN0, OWN1: begin
        grant_active = 1'b1;
        own_valid    = (state_q == OWN0) ? req0_valid : req1_valid;
        other_valid  = (state_q == OWN0) ? req1_valid : req0_valid;
        fifo_data_in = (state_q == OWN0) ? req0_data  : req1_data;
        fifo_push    = own_valid && !fifo_full;
        req0_ready   = fifo_push && (state_q == OWN0);
        req1_ready   = fifo_push && (state_q == OWN1);
        if (fifo_push) begin
          burst_cnt_d = burst_cnt_q + 4'd1;
        end
        limit_hit = fifo_push && ((burst_cnt_q + 4'd1) == MAX_CNT);
        if (!own_valid || limit_hit) begin
          if (other_valid) begin
            state_d     = (state_q == OWN0) ? OWN1 : OWN0;
            grant_id_d  = (state_q == OWN0);
            burst_cnt_d = 4'd0;
          end else if (limit_hit) begin
            // Sole requester at its burst limit: start a fresh burst.
            burst_cnt_d = 4'd0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant_id        = grant_id_q;
  assign dbg_state_o     = state_q;
  assign dbg_burst_cnt_o = burst_cnt_q;

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Directed bench for fifo_push_arbiter: producer queues feed the DUT and a
// per-producer expected queue checks every pushed word.
module tb_fifo_push_arbiter;

  localparam int W = 8;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_OWN0 = 2'd1;
  localparam logic [1:0] S_OWN1 = 2'd2;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0_valid, req1_valid;
  logic [W-1:0] req0_data, req1_data;
  logic         req0_ready, req1_ready;
  logic         fifo_full;
  logic         fifo_push;
  logic [W-1:0] fifo_data_in;
  logic         grant_active, grant_id;
  logic [1:0]   dbg_state;
  logic [3:0]   dbg_burst_cnt;

  logic [W-1:0] src0_q[$], src1_q[$];
  logic [W-1:0] exp0_q[$], exp1_q[$];
  logic         en0, en1;
  int           n_checks = 0;
  int           n_fail   = 0;

  fifo_push_arbiter #(.FIFO_WIDTH(W), .MAX_BURST(4)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .fifo_full(fifo_full), .fifo_push(fifo_push), .fifo_data_in(fifo_data_in),
    .grant_active(grant_active), .grant_id(grant_id),
    .dbg_state_o(dbg_state), .dbg_burst_cnt_o(dbg_burst_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive();
    req0_valid = en0 && (src0_q.size() > 0);
    req0_data  = (src0_q.size() > 0) ? src0_q[0] : '0;
    req1_valid = en1 && (src1_q.size() > 0);
    req1_data  = (src1_q.size() > 0) ? src1_q[0] : '0;
  endtask

  task automatic offer(input int p, input logic [W-1:0] w);
    if (p == 0) begin src0_q.push_back(w); exp0_q.push_back(w); en0 = 1'b1; end
    else        begin src1_q.push_back(w); exp1_q.push_back(w); en1 = 1'b1; end
  endtask

  // One clock: monitor at negedge, advance producers after the edge.
  task automatic tick();
    logic acc0, acc1;
    @(negedge clk);
    check("push_while_full", {31'd0, fifo_push & fifo_full}, 32'd0);
    check("push_vs_ready", {31'd0, fifo_push}, {31'd0, req0_ready | req1_ready});
    acc0 = req0_ready;
    acc1 = req1_ready;
    if (acc0) begin
      if (exp0_q.size() == 0) check("sb0_extra_word", 32'd1, 32'd0);
      else check("sb0_data", {24'd0, fifo_data_in}, {24'd0, exp0_q.pop_front()});
    end
    if (acc1) begin
      if (exp1_q.size() == 0) check("sb1_extra_word", 32'd1, 32'd0);
      else check("sb1_data", {24'd0, fifo_data_in}, {24'd0, exp1_q.pop_front()});
    end
    @(posedge clk);
    #1;
    if (acc0 && src0_q.size() > 0) void'(src0_q.pop_front());
    if (acc1 && src1_q.size() > 0) void'(src1_q.pop_front());
    drive();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    fifo_full = 1'b0;
    en0 = 1'b0; en1 = 1'b0;
    src0_q.delete(); src1_q.delete(); exp0_q.delete(); exp1_q.delete();
    drive();
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
  endtask

  task automatic check_idle_outputs(input string tag, input logic exp_gid);
    check({tag, "_state"}, {30'd0, dbg_state}, {30'd0, S_IDLE});
    check({tag, "_gact"}, {31'd0, grant_active}, 32'd0);
    check({tag, "_gid"}, {31'd0, grant_id}, {31'd0, exp_gid});
    check({tag, "_push"}, {31'd0, fifo_push}, 32'd0);
    check({tag, "_rdy"}, {30'd0, req0_ready, req1_ready}, 32'd0);
    check({tag, "_data"}, {24'd0, fifo_data_in}, 32'd0);
  endtask

  initial begin
    logic [W-1:0] w;
    int b, p, idx;
    reset = 1'b1;
    fifo_full = 1'b0;
    en0 = 1'b0; en1 = 1'b0;
    drive();

    // Reset state and a single producer pushing AA, BB, CC.
    do_reset();
    check_idle_outputs("rst", 1'b1);
    check("rst_cnt", {28'd0, dbg_burst_cnt}, 32'd0);
    offer(0, 8'hAA); offer(0, 8'hBB); offer(0, 8'hCC);
    drive();
    #1;
    check("t1_no_early_push", {31'd0, fifo_push}, 32'd0);
    tick();
    check("t1_own0", {30'd0, dbg_state}, {30'd0, S_OWN0});
    check("t1_gid", {31'd0, grant_id}, 32'd0);
    check("t1_d0", {24'd0, fifo_data_in}, 32'hAA);
    tick();
    check("t1_cnt1", {28'd0, dbg_burst_cnt}, 32'd1);
    check("t1_d1", {24'd0, fifo_data_in}, 32'hBB);
    tick();
    check("t1_d2", {24'd0, fifo_data_in}, 32'hCC);
    tick();
    check("t1_cnt3", {28'd0, dbg_burst_cnt}, 32'd3);
    check("t1_push_off", {31'd0, fifo_push}, 32'd0);
    tick();
    check_idle_outputs("t1_end", 1'b0);

    // Both producers continuously: alternating 4-word bursts, no gaps.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      offer(0, 8'h10 + 8'(i));
      offer(1, 8'h20 + 8'(i));
    end
    drive();
    #1;
    tick();
    for (int k = 0; k < 16; k++) begin
      b   = k / 4;
      p   = b & 1;
      idx = (b / 2) * 4 + (k % 4);
      w   = (p == 1) ? 8'h20 + 8'(idx) : 8'h10 + 8'(idx);
      check("t2_push", {31'd0, fifo_push}, 32'd1);
      check("t2_gid", {31'd0, grant_id}, p);
      check("t2_data", {24'd0, fifo_data_in}, {24'd0, w});
      check("t2_cnt", {28'd0, dbg_burst_cnt}, k % 4);
      tick();
    end
    tick();
    check("t2_idle", {30'd0, dbg_state}, {30'd0, S_IDLE});

    // Backpressure for 3 cycles mid-burst.
    do_reset();
    for (int i = 0; i < 5; i++) offer(0, 8'h30 + 8'(i));
    drive();
    tick();
    tick();
    check("t3_cnt1", {28'd0, dbg_burst_cnt}, 32'd1);
    fifo_full = 1'b1;
    #1;
    check("t3_full_push", {31'd0, fifo_push}, 32'd0);
    check("t3_full_rdy", {31'd0, req0_ready}, 32'd0);
    check("t3_full_data", {24'd0, fifo_data_in}, 32'h31);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3_hold_cnt", {28'd0, dbg_burst_cnt}, 32'd1);
      check("t3_hold_state", {30'd0, dbg_state}, {30'd0, S_OWN0});
    end
    fifo_full = 1'b0;
    #1;
    check("t3_resume", {31'd0, fifo_push}, 32'd1);
    tick();
    check("t3_cnt2", {28'd0, dbg_burst_cnt}, 32'd2);
    tick();
    tick();
    check("t3_reenter_state", {30'd0, dbg_state}, {30'd0, S_OWN0});
    check("t3_reenter_cnt", {28'd0, dbg_burst_cnt}, 32'd0);
    check("t3_reenter_data", {24'd0, fifo_data_in}, 32'h34);
    tick();
    tick();
    check("t3_idle", {30'd0, dbg_state}, {30'd0, S_IDLE});

    // Owner withdraws valid while the FIFO is full: must still release.
    do_reset();
    fifo_full = 1'b1;
    offer(1, 8'h99);
    drive();
    tick();
    check("t3b_own1", {30'd0, dbg_state}, {30'd0, S_OWN1});
    check("t3b_no_push", {31'd0, fifo_push}, 32'd0);
    en1 = 1'b0;
    void'(src1_q.pop_front());
    void'(exp1_q.pop_front());
    drive();
    tick();
    check("t3b_release", {30'd0, dbg_state}, {30'd0, S_IDLE});
    check("t3b_gid", {31'd0, grant_id}, 32'd1);
    fifo_full = 1'b0;

    // Lone producer 1 with 9 words: repeated bursts under one grant.
    do_reset();
    for (int i = 0; i < 9; i++) offer(1, 8'h40 + 8'(i));
    drive();
    tick();
    for (int k = 0; k < 9; k++) begin
      check("t4_state", {30'd0, dbg_state}, {30'd0, S_OWN1});
      check("t4_push", {31'd0, fifo_push}, 32'd1);
      check("t4_cnt", {28'd0, dbg_burst_cnt}, k % 4);
      check("t4_data", {24'd0, fifo_data_in}, 32'h40 + k);
      tick();
    end
    check("t4_cnt_end", {28'd0, dbg_burst_cnt}, 32'd1);
    tick();
    check("t4_idle", {30'd0, dbg_state}, {30'd0, S_IDLE});

    // Reset asserted between edges mid-burst, then contention after release.
    do_reset();
    for (int i = 0; i < 4; i++) offer(0, 8'h50 + 8'(i));
    drive();
    tick();
    tick();
    #1;
    reset = 1'b1;
    #1;
    check_idle_outputs("t5_async", 1'b1);
    check("t5_async_cnt", {28'd0, dbg_burst_cnt}, 32'd0);
    do_reset();
    offer(0, 8'h60); offer(0, 8'h61);
    offer(1, 8'h70); offer(1, 8'h71);
    drive();
    tick();
    check("t5_first_owner", {30'd0, dbg_state}, {30'd0, S_OWN0});
    check("t5_first_gid", {31'd0, grant_id}, 32'd0);
    for (int i = 0; i < 30 && (src0_q.size() > 0 || src1_q.size() > 0 || dbg_state != S_IDLE); i++)
      tick();
    check("t5_drain_done", {30'd0, dbg_state}, {30'd0, S_IDLE});
    check("t5_exp0_empty", exp0_q.size(), 32'd0);
    check("t5_exp1_empty", exp1_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
